// File: rtl/dual_counter_arbiter_pkg.sv
// Shared constants and helpers for the dual counter arbiter.
package ctr_arb_pkg;

  localparam int   PEND_W_DEF = 4;
  localparam int   NUM_REQ    = 2;

  localparam logic SEL_CNT0   = 1'b0;
  localparam logic SEL_CNT1   = 1'b1;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_PRIO  = 1'b1;

  // One arbitration decision: whether a grant happens and to whom.
  typedef struct packed {
    logic vld;
    logic id;
  } grant_t;

  // Pick a winner from the eligible set. Round-robin favours the requester
  // that was not granted last; priority mode always favours requester 0.
  function automatic grant_t pick_grant(logic [NUM_REQ-1:0] elig, logic mode, logic last);
    grant_t g;
    g.vld = 1'b0;
    g.id  = SEL_CNT0;
    case (elig)
      2'b01: begin g.vld = 1'b1; g.id = SEL_CNT0; end
      2'b10: begin g.vld = 1'b1; g.id = SEL_CNT1; end
      2'b11: begin
        g.vld = 1'b1;
        g.id  = (mode == MODE_PRIO) ? SEL_CNT0 : ~last;
      end
      default: ;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/dual_counter_arbiter_pend_counter.sv
// Saturating backlog counter: +1 per accepted request, -1 per grant,
// sticky drop flag when a request arrives at max with nothing draining.
module pend_counter
  import ctr_arb_pkg::*;
#(
  parameter int W = PEND_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         drop
);

  logic sat;
  assign sat = &cnt;

  // Backlog update; a simultaneous inc/dec cancels, which also accepts a
  // request at saturation without raising drop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt  <= '0;
      drop <= 1'b0;
    end else if (dec && !inc) begin
      cnt <= cnt - 1'b1;
    end else if (inc && !dec) begin
      if (sat) drop <= 1'b1;
      else     cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dual_counter_arbiter.sv
// Two-requester increment scheduler driving a shared dual counter bank.
// Requests are buffered per requester; at most one grant per cycle.
module dual_counter_arbiter
  import ctr_arb_pkg::*;
#(
  parameter int PEND_W = PEND_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              hold,
  input  logic              mode,
  output logic              sel,
  output logic              en,
  output logic [PEND_W-1:0] pend0,
  output logic [PEND_W-1:0] pend1,
  output logic              busy,
  output logic              drop0,
  output logic              drop1
);

  logic [NUM_REQ-1:0][PEND_W-1:0] pend;
  logic [NUM_REQ-1:0]             drop;
  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ-1:0]             elig;
  logic [NUM_REQ-1:0]             dec;
  logic                           last;
  grant_t                         gnt;

  assign req = {req1, req0};

  // Eligibility and grant come from registered backlog only, so the
  // decision made this cycle lands on the bank at the next edge.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++)
      elig[i] = !hold && (pend[i] != '0);
    gnt = pick_grant(elig, mode, last);
    dec = '0;
    if (gnt.vld) dec[gnt.id] = 1'b1;
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_pend
    pend_counter #(.W(PEND_W)) u_pend (
      .clk   (clk),
      .reset (reset),
      .inc   (req[i]),
      .dec   (dec[i]),
      .cnt   (pend[i]),
      .drop  (drop[i])
    );
  end

  // Bank drive and round-robin pointer; sel only moves on a grant so the
  // bank never sees a select change while idle. last=1 lets req0 win first.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sel  <= SEL_CNT0;
      en   <= 1'b0;
      last <= SEL_CNT1;
    end else begin
      en <= gnt.vld;
      if (gnt.vld) begin
        sel  <= gnt.id;
        last <= gnt.id;
      end
    end
  end

  assign pend0 = pend[0];
  assign pend1 = pend[1];
  assign drop0 = drop[0];
  assign drop1 = drop[1];
  assign busy  = (pend[0] != '0) || (pend[1] != '0);

endmodule

// File: tb/tb_dual_counter_arbiter.sv
// Scoreboard bench for dual_counter_arbiter: a cycle model predicts every
// output after each edge, plus directed checks on the bank totals and
// grant order for the key scenarios.
module tb_dual_counter_arbiter;

  localparam int PW  = 4;
  localparam int MAX = 15;

  logic clk, reset, req0, req1, hold, mode;
  logic sel, en, busy, drop0, drop1;
  logic [PW-1:0] pend0, pend1;

  dual_counter_arbiter #(.PEND_W(PW)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .hold(hold), .mode(mode),
    .sel(sel), .en(en), .pend0(pend0), .pend1(pend1), .busy(busy),
    .drop0(drop0), .drop1(drop1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter bank stand-in: counts enabled increments per output.
  int out0 = 0, out1 = 0;
  always @(posedge clk) if (en) begin
    if (sel) out1 <= out1 + 1;
    else     out0 <= out0 + 1;
  end

  typedef struct {
    logic en, sel, busy, d0, d1;
    int   p0, p1;
  } exp_t;

  exp_t sb[$];
  logic gq[$];   // observed sel of every enabled cycle

  int n_chk = 0, n_fail = 0;

  // model state
  int   m_p0, m_p1;
  logic m_last, m_sel, m_en, m_d0, m_d1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic upd(input logic r, input logic g, inout int p, inout logic d);
    if (r && g) ;
    else if (g) p = p - 1;
    else if (r) begin
      if (p == MAX) d = 1'b1;
      else p = p + 1;
    end
  endtask

  task automatic model(input logic rs, q0, q1, h, m);
    logic e0, e1, gv, gid;
    exp_t e;
    if (!rs) begin
      m_p0 = 0; m_p1 = 0; m_last = 1'b1; m_sel = 1'b0; m_en = 1'b0;
      m_d0 = 1'b0; m_d1 = 1'b0;
    end else begin
      e0 = !h && m_p0 != 0;
      e1 = !h && m_p1 != 0;
      gv = e0 || e1;
      if (e0 && e1) gid = m ? 1'b0 : (m_last ? 1'b0 : 1'b1);
      else          gid = e1;
      upd(q0, gv && !gid, m_p0, m_d0);
      upd(q1, gv &&  gid, m_p1, m_d1);
      m_en = gv;
      if (gv) begin m_sel = gid; m_last = gid; end
    end
    e.en = m_en; e.sel = m_sel; e.p0 = m_p0; e.p1 = m_p1;
    e.busy = (m_p0 != 0) || (m_p1 != 0); e.d0 = m_d0; e.d1 = m_d1;
    sb.push_back(e);
  endtask

  task automatic step(input logic rs, q0, q1, h, m);
    exp_t e;
    reset = rs; req0 = q0; req1 = q1; hold = h; mode = m;
    model(rs, q0, q1, h, m);
    @(posedge clk); #1;
    e = sb.pop_front();
    check("en",    en,    e.en);
    check("sel",   sel,   e.sel);
    check("pend0", pend0, e.p0[PW-1:0]);
    check("pend1", pend1, e.p1[PW-1:0]);
    check("busy",  busy,  e.busy);
    check("drop0", drop0, e.d0);
    check("drop1", drop1, e.d1);
    if (en) gq.push_back(sel);
  endtask

  int b0, b1;

  initial begin
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0; hold = 1'b0; mode = 1'b0;

    // reset, then 10 idle cycles
    step(0,0,0,0,0); step(0,0,0,0,0);
    for (int i = 0; i < 10; i++) step(1,0,0,0,0);
    check("idle_en", en, 1'b0);
    check("idle_busy", busy, 1'b0);

    // single req0 pulse: 2-edge latency, bank +1
    b0 = out0; b1 = out1;
    step(1,1,0,0,0);
    check("t2_pend0_after_t", pend0, 1);
    step(1,0,0,0,0);
    check("t2_en_after_t1", en, 1'b1);
    check("t2_sel_after_t1", sel, 1'b0);
    step(1,0,0,0,0);
    check("t2_en_after_t2", en, 1'b0);
    check("t2_bank0", out0 - b0, 1);
    check("t2_bank1", out1 - b1, 0);

    // both requesters once, round-robin from reset: 0 then 1
    step(0,0,0,0,0);
    gq.delete(); b0 = out0; b1 = out1;
    step(1,1,1,0,0);
    for (int i = 0; i < 4; i++) step(1,0,0,0,0);
    check("t3_ngrants", gq.size(), 2);
    if (gq.size() == 2) begin
      check("t3_first", gq[0], 1'b0);
      check("t3_second", gq[1], 1'b1);
    end
    check("t3_bank0", out0 - b0, 1);
    check("t3_bank1", out1 - b1, 1);
    check("t3_busy", busy, 1'b0);

    // priority mode: load 3/3 under hold, then drain 0,0,0,1,1,1
    for (int i = 0; i < 3; i++) step(1,1,1,1,1);
    check("t4_p0", pend0, 3);
    check("t4_p1", pend1, 3);
    gq.delete();
    for (int i = 0; i < 6; i++) step(1,0,0,0,1);
    check("t4_contig", gq.size(), 6);
    for (int i = 0; i < 2; i++) step(1,0,0,0,1);
    check("t4_ngrants", gq.size(), 6);
    if (gq.size() == 6)
      for (int i = 0; i < 6; i++) check("t4_order", gq[i], (i < 3) ? 1'b0 : 1'b1);

    // saturation under hold: 20 req1, 15 kept, drop1 set
    gq.delete();
    for (int i = 0; i < 15; i++) step(1,0,1,1,0);
    check("t5_drop1_pre", drop1, 1'b0);
    for (int i = 0; i < 5; i++) step(1,0,1,1,0);
    check("t5_pend1_sat", pend1, MAX);
    check("t5_drop1", drop1, 1'b1);
    check("t5_no_en", gq.size(), 0);
    b1 = out1;
    for (int i = 0; i < 17; i++) step(1,0,0,0,0);
    check("t5_grants", gq.size(), MAX);
    check("t5_bank1", out1 - b1, MAX);
    check("t5_pend1_empty", pend1, 0);

    // reset mid-operation with pend0=5 and en=1
    for (int i = 0; i < 6; i++) step(1,1,0,1,0);
    step(1,0,0,0,0);
    check("t6_pre_p0", pend0, 5);
    check("t6_pre_en", en, 1'b1);
    step(0,0,0,0,0);
    check("t6_p0", pend0, 0);
    check("t6_en", en, 1'b0);
    check("t6_drop1", drop1, 1'b0);
    gq.delete();
    step(1,0,1,0,0);
    check("t6_p1", pend1, 1);
    step(1,0,0,0,0);
    check("t6_en1", en, 1'b1);
    check("t6_sel1", sel, 1'b1);

    // random traffic, all modes
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0,49) != 0), 1'($urandom), 1'($urandom),
           ($urandom_range(0,3) == 0), 1'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dual_counter_arbiter.md
Name: dual_counter_arbiter

Overview:
- Schedules increment requests from two independent requesters onto the shared dual 64-bit counter bank.
- The bank takes Sel (counter select: 0 → Output0, 1 → Output1) and En (count enable, one increment per enabled cycle).
- The block buffers requests in per-requester pending counters and grants at most one increment per cycle, round-robin or fixed-priority.
- It drives the bank's Sel/En directly and reports backlog, activity and drop status.

Parameters:
- PEND_W, 4: width of each pending-request counter; saturates at 2^PEND_W-1 (default 15).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-low reset; sampled on rising Clk.
- Req0  input  1  one increment request for counter 0, per cycle high.
- Req1  input  1  one increment request for counter 1, per cycle high.
- Hold  input  1  1 = suppress new grants; requests still accumulate.
- Mode  input  1  0 = round-robin, 1 = fixed priority (requester 0 wins).
- Sel  output  1  registered counter select to the counter bank.
- En  output  1  registered count enable to the counter bank.
- Pend0  output  PEND_W  pending count, requester 0.
- Pend1  output  PEND_W  pending count, requester 1.
- Busy  output  1  1 when Pend0 != 0 or Pend1 != 0.
- Drop0  output  1  sticky: a Req0 was lost at saturation.
- Drop1  output  1  sticky: a Req1 was lost at saturation.

Behaviour:
- Reset (Reset==0 at posedge) takes priority over everything and applies mid-operation too. All outputs, pending counters and the pointer clear: Sel=0, En=0, Pend0=Pend1=0, Drop0=Drop1=0, Last=1 (so requester 0 wins first).
- Arbitration state is a 1-bit pointer Last = requester granted most recently; it updates only on a grant.
- Grant decision is combinational from the current registers; grant applies at the next edge. With Hold==1, Eligible = none. Otherwise Eligible_i = (Pend_i != 0).
  - None eligible: no grant.
  - One eligible: grant it.
  - Both eligible, Mode=1: grant 0.
  - Both eligible, Mode=0: grant the requester != Last.
- On a grant to i at an edge: En<=1, Sel<=i, Last<=i, Pend_i decrements. With no grant: En<=0, and Sel holds its previous value (no glitching of select).
- Pending update per requester per edge:
  - +1 if Req_i and not saturated.
  - -1 if granted.
  - Req_i and grant in the same edge: unchanged.
  - Req_i at saturation with no grant on that edge: count stays at max, Drop_i<=1.
  - At saturation with a simultaneous grant, the request is accepted (net unchanged); no drop.
- Latency: Req_i high at edge t with an empty backlog gives Pend_i=1 after t, and En=1/Sel=i visible after t+1. That is 2 edges of latency from request to enable.
- Throughput: one grant per cycle max. Sustained Req0&Req1 every cycle under round-robin grows each backlog by 1 every 2 cycles until saturation.
- Hold asserted: En drops to 0 at the next edge, and Pend counters only increment. On Hold deassert, grants resume the following edge with no loss.
- Mode may change any cycle; it takes effect for the next decision. Last keeps tracking grants in both modes.
- Drop_i clears only by reset.
- Busy is combinational from the pending registers.

Decomposition:
- Shared package `ctr_arb_pkg`:
  - constant PEND_W_DEF=4.
  - localparams SEL_CNT0=1'b0, SEL_CNT1=1'b1.
  - mode encodings MODE_RR=1'b0, MODE_PRIO=1'b1.
- One natural sub-module: `pend_counter` (saturating up/down counter with inc, dec and sticky drop), instantiated twice.
- The arbiter and output registers stay in the top.

Test Plan:
- Reset release, no Req for 10 cycles → En=0, Sel=0, Pend0=Pend1=0, Busy=0 throughout.
- Single Req0 pulse at edge t → Pend0=1 after t; En=1, Sel=0 after t+1; En=0, Pend0=0 after t+2. Counter bank Output0 increments by exactly 1.
- Req0=Req1=1 for one cycle, Mode=0 → grants in order Sel=0 then Sel=1 on consecutive cycles; Output0 and Output1 each +1; Busy falls after the second grant.
- Mode=1, both backlogs loaded to 3 with Hold=1, then Hold=0 → three Sel=0 grants, then three Sel=1 grants; En continuous for 6 cycles.
- Hold=1, Req1 held for 20 cycles → Pend1 saturates at 15, Drop1=1 from the 16th request on, En stays 0. Release Hold → exactly 15 Sel=1 grants.
- Reset asserted (Reset=0) while Pend0=5 and En=1 → after that edge Pend0=0, En=0, Sel=0, Drop flags 0; a new Req1 is then granted with the 2-edge latency.
